// File: rtl/mux_nx1_scan_if.sv
// Channel bank, select/mode/enable and tagged output word of the scanning N:1 mux.
// MUX_SCAN_SKIP_EN adds the per-channel skip_mask to the bundle.
interface mux_nx1_scan_if #(
    parameter int N_CH = 8,
    parameter int W    = 1
);
    localparam int SEL_W = $clog2(N_CH);

    logic [N_CH*W-1:0] in;
    logic [SEL_W-1:0]  sel;
    logic              mode;
    logic              en;
    logic [W-1:0]      out;
    logic [SEL_W-1:0]  out_ch;
    logic              out_valid;
    logic              wrap;
`ifdef MUX_SCAN_SKIP_EN
    logic [N_CH-1:0]   skip_mask;

    modport master (
        output in, sel, mode, en, skip_mask,
        input  out, out_ch, out_valid, wrap
    );
    modport slave (
        input  in, sel, mode, en, skip_mask,
        output out, out_ch, out_valid, wrap
    );
`else
    modport master (
        output in, sel, mode, en,
        input  out, out_ch, out_valid, wrap
    );
    modport slave (
        input  in, sel, mode, en,
        output out, out_ch, out_valid, wrap
    );
`endif
endinterface

// File: rtl/mux_nx1_scan.sv
// Registered N:1 mux, 1-cycle latency; manual select or timed scan over all channels.
// en=0 freezes scan position and output word, dropping out_valid/wrap; MUX_SCAN_SKIP_EN enables skip_mask.
module mux_nx1_scan #(
    parameter int N_CH  = 8,
    parameter int W     = 1,
    parameter int DWELL = 4
) (
    input  logic          clk,
    input  logic          rst,
    mux_nx1_scan_if.slave bus
);
    localparam int SEL_W = $clog2(N_CH);
    localparam int DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0]  DW_LAST = DW_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(N_CH - 1);

    typedef enum logic {S_MAN, S_SCAN} state_t;

    state_t           state_q, state_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic [DW_W-1:0]  dw_q, dw_d;
    logic [W-1:0]     out_q, out_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic             wrap_q, wrap_d;

    logic [W-1:0]     ch_dat [N_CH];
    logic             man_vld;
    logic [W-1:0]     man_dat;
    logic [SEL_W-1:0] scan_ch;
    logic [DW_W-1:0]  scan_dw;
    logic [SEL_W-1:0] first_ch;
    logic [SEL_W-1:0] adv_ch;
    logic             adv_wrap;
    logic             all_masked;
    logic             ch_masked;

    for (genvar k = 0; k < N_CH; k++) begin : g_unpack
        assign ch_dat[k] = bus.in[k*W +: W];
    end

    assign man_vld = int'(bus.sel) < N_CH;
    assign man_dat = man_vld ? ch_dat[bus.sel] : '0;

    // The entry edge is itself the first dwell cycle of the first channel, so the
    // scan step is always evaluated from (scan_ch, scan_dw) rather than (ch_q, dw_q).
    assign scan_ch = (state_q == S_SCAN) ? ch_q : first_ch;
    assign scan_dw = (state_q == S_SCAN) ? dw_q : '0;

`ifdef MUX_SCAN_SKIP_EN
    logic adv_found;

    assign all_masked = &bus.skip_mask;
    assign ch_masked  = bus.skip_mask[scan_ch];

    always_comb begin
        first_ch = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (!bus.skip_mask[i]) begin
                first_ch = SEL_W'(i);
            end
        end
    end

    // Circular search for the next unmasked index; passing N_CH-1 counts as a wrap.
    always_comb begin
        adv_ch    = scan_ch;
        adv_wrap  = 1'b0;
        adv_found = 1'b0;
        for (int i = 1; i <= N_CH; i++) begin
            if (!adv_found && !bus.skip_mask[(int'(scan_ch) + i) % N_CH]) begin
                adv_found = 1'b1;
                adv_ch    = SEL_W'((int'(scan_ch) + i) % N_CH);
                adv_wrap  = (int'(scan_ch) + i) >= N_CH;
            end
        end
    end
`else
    assign all_masked = 1'b0;
    assign ch_masked  = 1'b0;
    assign first_ch   = '0;
    assign adv_wrap   = (scan_ch == CH_LAST);
    assign adv_ch     = adv_wrap ? '0 : scan_ch + SEL_W'(1);
`endif

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        dw_d        = dw_q;
        out_d       = out_q;
        out_ch_d    = out_ch_q;
        out_valid_d = 1'b0;
        wrap_d      = 1'b0;
        if (bus.en) begin
            if (!bus.mode) begin
                state_d     = S_MAN;
                out_d       = man_dat;
                out_ch_d    = bus.sel;
                out_valid_d = man_vld;
            end else begin
                state_d = S_SCAN;
                if (all_masked) begin
                    ch_d = scan_ch;
                    dw_d = '0;
                end else if (ch_masked) begin
                    ch_d   = adv_ch;
                    dw_d   = '0;
                    wrap_d = adv_wrap;
                end else begin
                    out_d       = ch_dat[scan_ch];
                    out_ch_d    = scan_ch;
                    out_valid_d = 1'b1;
                    if (scan_dw == DW_LAST) begin
                        ch_d   = adv_ch;
                        dw_d   = '0;
                        wrap_d = adv_wrap;
                    end else begin
                        ch_d = scan_ch;
                        dw_d = scan_dw + DW_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_MAN;
            ch_q        <= '0;
            dw_q        <= '0;
            out_q       <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            dw_q        <= dw_d;
            out_q       <= out_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            wrap_q      <= wrap_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;
    assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_mux_nx1_scan.sv
// Directed bench for mux_nx1_scan: 8x1 DWELL=4 instance, 6x4 instance, and
// (with MUX_SCAN_SKIP_EN) an 8x1 DWELL=1 instance exercising skip_mask.
module tb_mux_nx1_scan;
    logic clk = 1'b0;
    logic rst;
    int   n_run  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mux_nx1_scan_if #(.N_CH(8), .W(1)) ifa ();
    mux_nx1_scan #(.N_CH(8), .W(1), .DWELL(4)) dut_a (.clk(clk), .rst(rst), .bus(ifa));

    mux_nx1_scan_if #(.N_CH(6), .W(4)) ifb ();
    mux_nx1_scan #(.N_CH(6), .W(4), .DWELL(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

`ifdef MUX_SCAN_SKIP_EN
    mux_nx1_scan_if #(.N_CH(8), .W(1)) ifc ();
    mux_nx1_scan #(.N_CH(8), .W(1), .DWELL(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input int ch, input logic d, input logic v, input logic w);
        check({tag, " out_ch"},    32'(ifa.out_ch),    32'(ch));
        check({tag, " out"},       32'(ifa.out),       32'(d));
        check({tag, " out_valid"}, 32'(ifa.out_valid), 32'(v));
        check({tag, " wrap"},      32'(ifa.wrap),      32'(w));
    endtask

    // Hand-decoded channel values of 8'b1010_0110, 8'hA5
    logic man_bits  [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic scan_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int   seq_after_en [8] = '{3, 3, 4, 4, 4, 4, 5, 5};

    initial begin
        rst = 1'b1;
        ifa.in = '0; ifa.sel = '0; ifa.mode = 1'b0; ifa.en = 1'b0;
        ifb.in = '0; ifb.sel = '0; ifb.mode = 1'b0; ifb.en = 1'b0;
`ifdef MUX_SCAN_SKIP_EN
        ifa.skip_mask = '0;
        ifb.skip_mask = '0;
        ifc.in = '0; ifc.sel = '0; ifc.mode = 1'b0; ifc.en = 1'b0; ifc.skip_mask = '0;
`endif
        tick();
        tick();
        check_a("reset", 0, 1'b0, 1'b0, 1'b0);

        // Manual sweep
        rst = 1'b0;
        ifa.en = 1'b1;
        ifa.in = 8'b1010_0110;
        for (int s = 0; s < 8; s++) begin
            ifa.sel = 3'(s);
            tick();
            check_a($sformatf("manual sel=%0d", s), s, man_bits[s], 1'b1, 1'b0);
        end

        // Scan 40 cycles from manual; entry edge is the first of four on channel 0
        ifa.in   = 8'hA5;
        ifa.mode = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            tick();
            check_a($sformatf("scan c=%0d", c), ((c - 1) / 4) % 8,
                    scan_bits[((c - 1) / 4) % 8], 1'b1, (c == 32));
        end

        // Channel 2 for four cycles, then channel 3 reaches dw=2
        for (int c = 0; c < 6; c++) begin
            tick();
            check_a($sformatf("scan cont c=%0d", c), (c < 4) ? 2 : 3,
                    (c < 4) ? 1'b1 : 1'b0, 1'b1, 1'b0);
        end

        // Freeze at ch=3 dw=2; changed inputs must not reach out
        ifa.en = 1'b0;
        ifa.in = 8'hFF;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_a($sformatf("en0 hold c=%0d", c), 3, 1'b0, 1'b0, 1'b0);
        end
        ifa.en = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            check_a($sformatf("resume c=%0d", c), seq_after_en[c], 1'b1, 1'b1, 1'b0);
        end

        // Reset mid-scan at ch=5
        rst = 1'b1;
        tick();
        check_a("rst mid-scan 1", 0, 1'b0, 1'b0, 1'b0);
        tick();
        check_a("rst mid-scan 2", 0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_a($sformatf("restart c=%0d", c), (c < 4) ? 0 : 1, 1'b1, 1'b1, 1'b0);
        end
        ifa.en = 1'b0;

        // 6-channel, 4-bit instance in manual mode
        ifb.en = 1'b1;
        ifb.in = 24'hC5_4321;
        ifb.sel = 3'd7;
        tick();
        check("n6 sel7 out",       32'(ifb.out),       32'h0);
        check("n6 sel7 out_ch",    32'(ifb.out_ch),    32'd7);
        check("n6 sel7 out_valid", 32'(ifb.out_valid), 32'd0);
        ifb.sel = 3'd5;
        tick();
        check("n6 sel5 out",       32'(ifb.out),       32'hC);
        check("n6 sel5 out_ch",    32'(ifb.out_ch),    32'd5);
        check("n6 sel5 out_valid", 32'(ifb.out_valid), 32'd1);
        ifb.sel = 3'd2;
        tick();
        check("n6 sel2 out",       32'(ifb.out),       32'h3);
        ifb.sel = 3'd6;
        tick();
        check("n6 sel6 out",       32'(ifb.out),       32'h0);
        check("n6 sel6 out_valid", 32'(ifb.out_valid), 32'd0);
        ifb.sel = 3'd1;
        tick();
        ifb.en = 1'b0;
        ifb.sel = 3'd4;
        tick();
        check("n6 en0 out",        32'(ifb.out),       32'h2);
        check("n6 en0 out_ch",     32'(ifb.out_ch),    32'd1);
        check("n6 en0 out_valid",  32'(ifb.out_valid), 32'd0);

`ifdef MUX_SCAN_SKIP_EN
        begin
            int skip_seq  [7] = '{0, 3, 4, 5, 6, 0, 3};
            logic skip_wr [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            ifc.in        = 8'b0101_1001;
            ifc.skip_mask = 8'b1000_0110;
            ifc.en        = 1'b1;
            ifc.mode      = 1'b1;
            for (int c = 0; c < 7; c++) begin
                tick();
                check($sformatf("skip out_ch c=%0d", c), 32'(ifc.out_ch),    32'(skip_seq[c]));
                check($sformatf("skip wrap c=%0d", c),   32'(ifc.wrap),      32'(skip_wr[c]));
                check($sformatf("skip valid c=%0d", c),  32'(ifc.out_valid), 32'd1);
            end
            ifc.skip_mask = 8'hFF;
            for (int c = 0; c < 2; c++) begin
                tick();
                check($sformatf("allmask valid c=%0d", c), 32'(ifc.out_valid), 32'd0);
                check($sformatf("allmask wrap c=%0d", c),  32'(ifc.wrap),      32'd0);
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_nx1_scan.md
Name: mux_nx1_scan

Overview:
- Parametrised N-channel, W-bit-wide registered multiplexer; next generation of the 8:1 combinational mux.
- Two modes:
  - Manual: external select picks the channel.
  - Scan: an internal counter steps through every channel, staying on each one for a programmable number of cycles.
- Sits between a bank of sensor/data channels and a single downstream consumer. Reports channel index and data valid with each output word.

Parameters:
- N_CH, 8, number of input channels (>=2).
- W, 1, bit width of each channel.
- DWELL, 4, cycles spent on each channel in scan mode (>=1).
- SEL_W, $clog2(N_CH), select/index width. Derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in  input  N_CH*W  packed channels; channel k = in[k*W +: W].
- sel  input  SEL_W  manual-mode channel select.
- mode  input  1  0 = manual, 1 = scan.
- en  input  1  clock enable for the whole block.
- out  output  W  registered selected data.
- out_ch  output  SEL_W  channel index that produced out.
- out_valid  output  1  out/out_ch are meaningful this cycle.
- wrap  output  1  one-cycle pulse when the scan completes a pass (last channel to channel 0).

Behaviour:
- Reset: while rst=1 at a clock edge, registers take these values. Reset has priority over everything, including mid-scan.
  - out=0, out_ch=0, out_valid=0, wrap=0.
  - Scan channel counter ch=0, dwell counter dw=0, state=S_MAN.
- State machine, two states. Transitions are sampled only when en=1.
  - S_MAN -> S_SCAN when mode=1. The transition edge clears ch=0 and dw=0, and drives out<=in[0], out_ch<=0, out_valid<=1 on that same edge.
  - S_SCAN -> S_MAN when mode=0. The transition edge behaves as manual.
- Latency: 1 cycle. Output seen after edge t reflects in/sel sampled at edge t.
- Manual (en=1):
  - sel < N_CH: out<=in[sel], out_ch<=sel, out_valid<=1.
  - sel >= N_CH (non-power-of-2 N_CH): out<=0, out_ch<=sel, out_valid<=0.
  - wrap<=0.
- Scan (en=1, already in S_SCAN):
  - Each cycle: out<=in[ch], out_ch<=ch, out_valid<=1.
  - If dw==DWELL-1: dw<=0 and ch advances. If ch==N_CH-1, ch<=0 and wrap<=1 on this edge; otherwise ch<=ch+1.
  - Otherwise dw<=dw+1, wrap<=0.
  - Each channel appears on out for exactly DWELL consecutive enabled cycles.
- en=0:
  - ch, dw, state, out and out_ch hold.
  - out_valid<=0, wrap<=0.
  - Re-asserting en resumes the scan at the held ch/dw; no count is lost or repeated.
- DWELL=1: channel advances every enabled cycle; wrap every N_CH enabled cycles.
- Input data is not registered before the mux; in may change every cycle.

Optional Feature:
- Macro: MUX_SCAN_SKIP_EN.
- Defined:
  - Adds input port skip_mask [N_CH-1:0]; bit k=1 excludes channel k from the scan.
  - On advance, ch moves to the next unmasked index above ch, circularly. wrap pulses whenever the advance passes through index N_CH-1 to a lower index.
  - On entering S_SCAN, ch = lowest unmasked index.
  - If ch itself is masked while dwelling, advance happens on the next edge regardless of dw.
  - If all bits are masked: out_valid<=0, ch holds, wrap<=0.
  - Manual mode ignores skip_mask.
- Undefined: port absent; all channels scanned; behaviour exactly as above.

Test Plan (N_CH=8, W=1, DWELL=4 unless noted):
- rst=1 for 2 cycles mid-scan (ch=5) -> out=0, out_ch=0, out_valid=0, wrap=0; after release with mode=1, scan restarts at ch 0.
- Manual, in=8'b1010_0110, sel swept 0..7 with en=1 -> out one cycle later = 0,1,1,0,0,1,0,1; out_ch=sel; out_valid=1.
- Scan, in=8'hA5, mode=1 for 40 cycles -> out_ch = 0×4, 1×4 … 7×4, then 0; out=in[out_ch]; wrap pulses once, on the edge where out_ch goes 7->0 (cycle 32).
- Scan with en=0 for 3 cycles at ch=3, dw=2 -> out/out_ch held, out_valid=0; after en=1, ch 3 shows for exactly 2 more cycles, then ch 4.
- N_CH=6, W=4, manual sel=7 -> out=0, out_ch=7, out_valid=0; sel=5 with in[23:20]=4'hC -> out=4'hC, out_valid=1.
- MUX_SCAN_SKIP_EN, skip_mask=8'b1000_0110, DWELL=1 -> out_ch sequence 0,3,4,5,6,0 with wrap on 6->0; skip_mask=8'hFF -> out_valid=0, wrap=0.
